vid_timing_lock: RTL

VID_TIMING_LOCK -- requirements
Module: vid_timing_lock

---
 rtl/vid_timing_lock.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/vid_timing_lock.sv
// Purpose: retime a pixel stream and verify its line/frame geometry, locking after consecutive good frames.
// Latency: every vid_* output, frame_err and err_count lag their inputs by exactly one clk cycle.
// Backpressure: none; the stream is free-running and a stalled strobe source is caught by the watchdog.
module vid_timing_lock #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int LOCK_FRAMES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] in_pixel,
    input  logic        in_pixsync,
    input  logic        in_hsync,
    input  logic        in_vsync,
    output logic [11:0] vid_pixel,
    output logic        vid_pixsync,
    output logic        vid_hblank,
    output logic        vid_vblank,
    output logic        vid_visible,
    output logic        vid_locked,
    output logic        frame_err,
    output logic [15:0] err_count
);

    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 2);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [PW-1:0] PIX_GOOD  = PW'(H_ACTIVE);
    localparam logic [PW-1:0] PIX_MAX   = PW'(H_ACTIVE + 1);
    localparam logic [LW-1:0] LINE_GOOD = LW'(V_ACTIVE);
    localparam logic [LW-1:0] LINE_MAX  = LW'(V_ACTIVE + 1);
    localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GF_LOCK   = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            hsync_prev_q, hsync_prev_d;
    logic            vsync_prev_q, vsync_prev_d;
    logic            edge_arm_q, edge_arm_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]   line_cnt_q, line_cnt_d;
    logic            bad_line_q, bad_line_d;
    logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
    logic [GW-1:0]   good_frames_q, good_frames_d;
    logic [11:0]     vid_pixel_q, vid_pixel_d;
    logic            vid_pixsync_q, vid_pixsync_d;
    logic            vid_hblank_q, vid_hblank_d;
    logic            vid_vblank_q, vid_vblank_d;
    logic            vid_visible_q, vid_visible_d;
    logic            vid_locked_q, vid_locked_d;
    logic            frame_err_q, frame_err_d;
    logic [15:0]     err_count_q, err_count_d;

    logic            hs_rise, hs_fall, vs_rise, vs_fall;
    logic            frame_act, line_good, frame_good, timeout, err_evt;
    logic [PW-1:0]   pix_base;
    logic [LW-1:0]   line_base;
    logic            bad_base;

    // Next-state logic: edge detection, geometry counters, watchdog, lock FSM and retimed outputs.
    always_comb begin
        // Edges are ignored for the first cycle after reset so a level already
        // high at release is never mistaken for a fresh line or frame start.
        hs_rise = edge_arm_q &  in_hsync & ~hsync_prev_q;
        hs_fall = edge_arm_q & ~in_hsync &  hsync_prev_q;
        vs_rise = edge_arm_q &  in_vsync & ~vsync_prev_q;
        vs_fall = edge_arm_q & ~in_vsync &  vsync_prev_q;

        edge_arm_d   = 1'b1;
        hsync_prev_d = in_hsync;
        vsync_prev_d = in_vsync;

        // Pixel counter: cleared by the line start, counts only in-line strobes.
        pix_base  = hs_rise ? '0 : pix_cnt_q;
        pix_cnt_d = pix_base;
        if (in_pixsync && in_hsync && (pix_base != PIX_MAX)) begin
            pix_cnt_d = pix_base + PW'(1);
        end
        line_good = (pix_cnt_q == PIX_GOOD);

        // The frame is still open in the cycle vsync falls, so a coincident
        // hsync fall is counted and judged before the frame verdict.
        frame_act  = in_vsync | vs_fall;
        line_base  = vs_rise ? '0 : line_cnt_q;
        bad_base   = vs_rise ? 1'b0 : bad_line_q;
        line_cnt_d = line_base;
        bad_line_d = bad_base;
        if (hs_fall && frame_act) begin
            if (line_base != LINE_MAX) begin
                line_cnt_d = line_base + LW'(1);
            end
            if (!line_good) begin
                bad_line_d = 1'b1;
            end
        end
        frame_good = (line_cnt_d == LINE_GOOD) && !bad_line_d;

        // Watchdog saturates at the limit, so the timeout fires once per stall.
        wd_cnt_d = wd_cnt_q;
        timeout  = 1'b0;
        if (in_pixsync) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + WW'(1);
            timeout  = (wd_cnt_q == WD_LAST);
        end

        state_d       = state_q;
        good_frames_d = good_frames_q;
        err_evt       = 1'b0;
        unique case (state_q)
            ST_UNLOCKED: begin
                if (vs_rise) begin
                    state_d       = ST_ACQUIRE;
                    good_frames_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (vs_fall) begin
                    if (frame_good) begin
                        good_frames_d = good_frames_q + GW'(1);
                        if (good_frames_d == GF_LOCK) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        state_d = ST_UNLOCKED;
                        err_evt = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (vs_fall && !frame_good) begin
                    state_d = ST_UNLOCKED;
                    err_evt = 1'b1;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
        if (timeout) begin
            state_d = ST_UNLOCKED;
            err_evt = 1'b1;
        end

        frame_err_d  = err_evt;
        err_count_d  = (err_evt && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1 : err_count_q;
        vid_locked_d = (state_d == ST_LOCKED);

        vid_pixel_d   = in_pixel;
        vid_pixsync_d = in_pixsync;
        vid_hblank_d  = ~in_hsync;
        vid_vblank_d  = ~in_vsync;
        vid_visible_d = in_pixsync & in_hsync & in_vsync &
                        (pix_base < PIX_GOOD) & (line_base < LINE_GOOD);
    end

    // State register with synchronous reset to the idle, unlocked picture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_UNLOCKED;
            hsync_prev_q  <= 1'b0;
            vsync_prev_q  <= 1'b0;
            edge_arm_q    <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            bad_line_q    <= 1'b0;
            wd_cnt_q      <= '0;
            good_frames_q <= '0;
            vid_pixel_q   <= 12'h000;
            vid_pixsync_q <= 1'b0;
            vid_hblank_q  <= 1'b1;
            vid_vblank_q  <= 1'b1;
            vid_visible_q <= 1'b0;
            vid_locked_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            err_count_q   <= 16'h0000;
        end else begin
            state_q       <= state_d;
            hsync_prev_q  <= hsync_prev_d;
            vsync_prev_q  <= vsync_prev_d;
            edge_arm_q    <= edge_arm_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            bad_line_q    <= bad_line_d;
            wd_cnt_q      <= wd_cnt_d;
            good_frames_q <= good_frames_d;
            vid_pixel_q   <= vid_pixel_d;
            vid_pixsync_q <= vid_pixsync_d;
            vid_hblank_q  <= vid_hblank_d;
            vid_vblank_q  <= vid_vblank_d;
            vid_visible_q <= vid_visible_d;
            vid_locked_q  <= vid_locked_d;
            frame_err_q   <= frame_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign vid_pixel   = vid_pixel_q;
    assign vid_pixsync = vid_pixsync_q;
    assign vid_hblank  = vid_hblank_q;
    assign vid_vblank  = vid_vblank_q;
    assign vid_visible = vid_visible_q;
    assign vid_locked  = vid_locked_q;
    assign frame_err   = frame_err_q;
    assign err_count   = err_count_q;

endmodule
